// File: rtl/booth_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Restoring division on magnitudes, one quotient bit per clock, then a sign fix-up.
module booth_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int unsigned CntW = $clog2(2 * WIDTH);
    localparam logic [2*WIDTH-1:0] QNegMax = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] QPosMax = QNegMax - {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e              state_q, state_d;
    logic                sgn_n_q, sgn_n_d;
    logic                sgn_d_q, sgn_d_d;
    logic                dbz_q, dbz_d;
    logic [2*WIDTH-1:0]  dvd_q, dvd_d;  // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0]    dvs_q, dvs_d;
    logic [WIDTH-1:0]    pr_q, pr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    quot_q, quot_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic [2*WIDTH-1:0]  dvd_mag;
    logic [WIDTH-1:0]    dvs_mag;
    logic [WIDTH:0]      pr_shift;
    logic                pr_ge;
    logic                q_neg;
    logic                q_ovf;

    always_comb begin
        // Unsigned magnitudes are exact here, including the most negative operand.
        dvd_mag  = dividend[2*WIDTH-1] ? (~dividend + 1'b1) : dividend;
        dvs_mag  = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
        pr_shift = {pr_q, dvd_q[2*WIDTH-1]};
        pr_ge    = pr_shift >= {1'b0, dvs_q};
        q_neg    = sgn_n_q ^ sgn_d_q;
        q_ovf    = dbz_q || (!q_neg && (dvd_q > QPosMax)) || (q_neg && (dvd_q > QNegMax));
    end

    always_comb begin
        state_d = state_q;
        sgn_n_d = sgn_n_q;
        sgn_d_d = sgn_d_q;
        dbz_d   = dbz_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    sgn_n_d = dividend[2*WIDTH-1];
                    sgn_d_d = divisor[WIDTH-1];
                    dbz_d   = (divisor == '0);
                    dvd_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    pr_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // The true difference is below |divisor|, so WIDTH bits hold it.
                pr_d  = pr_ge ? (pr_shift[WIDTH-1:0] - dvs_q) : pr_shift[WIDTH-1:0];
                dvd_d = {dvd_q[2*WIDTH-2:0], pr_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(2 * WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (q_ovf) begin
                    quot_d = '0;
                    rem_d  = '0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = q_neg ? (~dvd_q[WIDTH-1:0] + 1'b1) : dvd_q[WIDTH-1:0];
                    rem_d  = sgn_n_q ? (~pr_q + 1'b1) : pr_q;
                    ovf_d  = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sgn_n_q <= 1'b0;
            sgn_d_q <= 1'b0;
            dbz_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_n_q <= sgn_n_d;
            sgn_d_q <= sgn_d_d;
            dbz_q   <= dbz_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider at WIDTH=4.
module tb_booth_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quot;
    logic [3:0] rem;
    logic       busy;
    logic       done;
    logic       ovf;

    int checks;
    int failures;

    booth_divider #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quot     (quot),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with a one-cycle start; returns #1 after the start edge.
    task automatic kick(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts edges since the caller's last sample.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = int'(busy);
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done) bcnt += int'(busy);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic eo);
        int lat;
        int bcnt;
        kick(a, b);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_quot"}, quot, eq);
        chk({tag, "_rem"}, rem, er);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        int lat;
        int bcnt;
        int ndone;
        int first_d;
        int last_d;
        bit saw_done;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // -21 / 4 = -5 rem -1, with busy and done timing
        kick(8'hEB, 4'h4);
        chk("t1_busy_start", busy, 1);
        wait_done(lat, bcnt);
        chk("t1_lat", lat, 9);
        chk("t1_busy_cycles", bcnt, 9);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_quot", quot, 4'hB);
        chk("t1_rem", rem, 4'hF);
        chk("t1_ovf", ovf, 0);
        @(posedge clk);
        #1;
        chk("t1_done_one_cycle", done, 0);
        chk("t1_quot_hold", quot, 4'hB);

        run("t2", 8'd20, 4'hD, 4'hA, 4'h2, 1'b0);
        run("t3", 8'd49, 4'd7, 4'd7, 4'd0, 1'b0);
        run("t4", 8'd64, 4'h8, 4'h8, 4'd0, 1'b0);
        run("t5", 8'd64, 4'd7, 4'd0, 4'd0, 1'b1);
        run("t6", 8'h80, 4'hF, 4'd0, 4'd0, 1'b1);
        run("t7_dbz", 8'd15, 4'd0, 4'd0, 4'd0, 1'b1);
        run("t8", 8'hF9, 4'd2, 4'hD, 4'hF, 1'b0);

        // start pulsed mid-CALC with other operands must be ignored
        kick(8'd35, 4'd5);
        repeat (3) @(posedge clk);
        #1;
        dividend = 8'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("t9_lat", lat, 5);
        chk("t9_quot", quot, 4'd7);
        chk("t9_rem", rem, 4'd0);

        // start held high: done every 10th cycle
        @(negedge clk);
        dividend = 8'd49;
        divisor  = 4'd7;
        start    = 1'b1;
        ndone    = 0;
        first_d  = -1;
        last_d   = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_d < 0) first_d = i;
                last_d = i;
            end
        end
        start = 1'b0;
        chk("t10_ndone", ndone, 3);
        chk("t10_first", first_d, 9);
        chk("t10_span", last_d - first_d, 20);
        chk("t10_quot", quot, 4'd7);

        // asynchronous reset at CALC step 3
        kick(8'hEB, 4'h4);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t11_busy", busy, 0);
        chk("t11_done", done, 0);
        chk("t11_quot", quot, 0);
        chk("t11_rem", rem, 0);
        chk("t11_ovf", ovf, 0);
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("t11_no_done", saw_done, 0);
        run("t12", 8'd20, 4'hD, 4'hA, 4'h2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
